// File: rtl/bit_serializer_if.sv
// Word handshake between a producer and the bit serializer.
// The producer owns in_data/in_valid; the serializer owns in_ready.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: a one-word holding buffer feeds a shifter that
// emits a gapless bitstream, each bit held for DIV clock cycles.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned DIV       = 1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    bit_serializer_if.slave     in_if,
    output logic                dout,
    output logic                dout_valid,
    output logic                busy,
    output logic [15:0]         words_sent
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             dout_d;
    logic             dout_valid_d;
    logic [15:0]      sent_d;
    logic             load;
    logic             accept;

    assign accept = in_if.in_valid && in_if.in_ready;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            shreg_q         <= '0;
            div_q           <= '0;
            bit_q           <= '0;
            dout            <= IDLE_BIT;
            dout_valid      <= 1'b0;
            words_sent      <= '0;
            busy            <= 1'b0;
            in_if.in_ready  <= 1'b1;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            shreg_q         <= shreg_d;
            div_q           <= div_d;
            bit_q           <= bit_d;
            dout            <= dout_d;
            dout_valid      <= dout_valid_d;
            words_sent      <= sent_d;
            busy            <= (state_d == S_SHIFT) || hold_full_d;
            in_if.in_ready  <= !hold_full_d;
        end
    end

    // Next-state, shifter and holding-buffer logic
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shreg_d      = shreg_q;
        div_d        = div_q;
        bit_d        = bit_q;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        sent_d       = words_sent;
        load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                dout_d       = IDLE_BIT;
                dout_valid_d = 1'b0;
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        sent_d = words_sent + 16'd1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d      = S_IDLE;
                            dout_d       = IDLE_BIT;
                            dout_valid_d = 1'b0;
                        end
                    end else begin
                        bit_d   = bit_q + CNT_W'(1);
                        dout_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loading presents the first bit on the same edge; shreg keeps the rest
        if (load) begin
            state_d      = S_SHIFT;
            div_d        = '0;
            bit_d        = '0;
            dout_valid_d = 1'b1;
            dout_d       = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
            shreg_d      = MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
            hold_full_d  = 1'b0;
        end

        // in_ready is low while hold is full, so accept and drain never coincide
        if (accept) begin
            hold_d      = in_if.in_data;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three configurations (MSB-first DIV=1,
// DIV=3, LSB-first) share one clock and reset.
module tb_bit_serializer;

    logic clk;
    logic rst;

    bit_serializer_if #(.WIDTH(8)) ifa ();
    bit_serializer_if #(.WIDTH(8)) ifb ();
    bit_serializer_if #(.WIDTH(8)) ifc ();

    logic        dout_a, dv_a, busy_a;
    logic        dout_b, dv_b, busy_b;
    logic        dout_c, dv_c, busy_c;
    logic [15:0] ws_a, ws_b, ws_c;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_if(ifa.slave),
        .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .words_sent(ws_a)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DIV(3), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_if(ifb.slave),
        .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .words_sent(ws_b)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .DIV(1), .IDLE_BIT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_if(ifc.slave),
        .dout(dout_c), .dout_valid(dv_c), .busy(busy_c), .words_sent(ws_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    logic        exp_q[$];
    logic        got[$];
    int          got_first;
    int          got_last;
    logic [15:0] exp_sent [3];

    function automatic logic rdy(input int sel);
        case (sel)
            0: return ifa.in_ready;
            1: return ifb.in_ready;
            default: return ifc.in_ready;
        endcase
    endfunction

    function automatic logic vld(input int sel);
        case (sel)
            0: return dv_a;
            1: return dv_b;
            default: return dv_c;
        endcase
    endfunction

    function automatic logic dbit(input int sel);
        case (sel)
            0: return dout_a;
            1: return dout_b;
            default: return dout_c;
        endcase
    endfunction

    function automatic logic bsy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [15:0] wsent(input int sel);
        case (sel)
            0: return ws_a;
            1: return ws_b;
            default: return ws_c;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic [7:0] w, input logic v);
        case (sel)
            0: begin ifa.in_data = w; ifa.in_valid = v; end
            1: begin ifb.in_data = w; ifb.in_valid = v; end
            default: begin ifc.in_data = w; ifc.in_valid = v; end
        endcase
    endtask

    // Present a word at a falling edge and hold it until accepted
    task automatic send(input int sel, input logic [7:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy(sel) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL send_timeout dut%0d: in_ready stayed %b after %0d cycles, required 1", sel, rdy(sel), guard);
        end
        set_in(sel, w, 1'b1);
        @(posedge clk);
        #1;
        set_in(sel, w, 1'b0);
    endtask

    // Record dout on every falling edge where dout_valid is high
    task automatic capture(input int sel, input int ncyc);
        got.delete();
        got_first = -1;
        got_last  = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (vld(sel) === 1'b1) begin
                got.push_back(dbit(sel));
                if (got_first < 0) got_first = i;
                got_last = i;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if ({dbit(s), vld(s), rdy(s), bsy(s)} !== 4'b0010 || wsent(s) !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: dout/valid/ready/busy=%b%b%b%b ws=%0d, required 0010 ws=0",
                         s, dbit(s), vld(s), rdy(s), bsy(s), wsent(s));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        int idx;
        logic e, a;
        logic [7:0] w;
        w = 8'hD0;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        fork
            send(0, w);
            capture(0, 20);
        join
        exp_sent[0] = exp_sent[0] + 16'd1;
        n = got.size();
        n_tests++;
        if (n != 8) begin n_fail++; $display("FAIL single_count: got %0d valid bits, required 8", n); end
        n_tests++;
        if (got_first != 2) begin n_fail++; $display("FAIL single_latency: first bit at sample %0d, required 2", got_first); end
        n_tests++;
        if (got_last - got_first + 1 != 8) begin n_fail++; $display("FAIL single_gap: span %0d, required 8", got_last - got_first + 1); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 1'bx;
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL single_bit%0d: got %b, required %b", idx, a, e); end
            idx++;
        end
        n_tests++;
        if (ws_a !== exp_sent[0]) begin n_fail++; $display("FAIL single_words_sent: got %0d, required %0d", ws_a, exp_sent[0]); end
    endtask

    task automatic test_back_to_back();
        int n;
        int idx;
        logic e, a;
        logic [7:0] w0, w1;
        w0 = 8'hAA;
        w1 = 8'h55;
        for (int i = 7; i >= 0; i--) exp_q.push_back(w0[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
        fork
            begin
                send(0, w0);
                send(0, w1);
                @(negedge clk);
                n_tests++;
                if (ifa.in_ready !== 1'b0 || busy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_hold_full: in_ready=%b busy=%b, required 0 1", ifa.in_ready, busy_a);
                end
            end
            capture(0, 30);
        join
        exp_sent[0] = exp_sent[0] + 16'd2;
        n = got.size();
        n_tests++;
        if (n != 16) begin n_fail++; $display("FAIL b2b_count: got %0d valid bits, required 16", n); end
        n_tests++;
        if (got_last - got_first + 1 != 16) begin n_fail++; $display("FAIL b2b_gap: span %0d, required 16", got_last - got_first + 1); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 1'bx;
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL b2b_bit%0d: got %b, required %b", idx, a, e); end
            idx++;
        end
        n_tests++;
        if (ws_a !== exp_sent[0]) begin n_fail++; $display("FAIL b2b_words_sent: got %0d, required %0d", ws_a, exp_sent[0]); end
    endtask

    task automatic test_div();
        int n;
        int idx;
        logic e, a;
        logic [7:0] w;
        w = 8'h81;
        for (int i = 7; i >= 0; i--) repeat (3) exp_q.push_back(w[i]);
        fork
            send(1, w);
            capture(1, 40);
        join
        exp_sent[1] = exp_sent[1] + 16'd1;
        n = got.size();
        n_tests++;
        if (n != 24) begin n_fail++; $display("FAIL div_count: got %0d valid cycles, required 24", n); end
        n_tests++;
        if (got_first != 2 || got_last != 25) begin n_fail++; $display("FAIL div_window: samples %0d..%0d, required 2..25", got_first, got_last); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 1'bx;
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL div_cycle%0d: got %b, required %b", idx, a, e); end
            idx++;
        end
        n_tests++;
        if (ws_b !== exp_sent[1]) begin n_fail++; $display("FAIL div_words_sent: got %0d, required %0d", ws_b, exp_sent[1]); end
    endtask

    task automatic test_lsb_first();
        int n;
        int idx;
        logic e, a;
        logic [7:0] w;
        w = 8'h0B;
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        fork
            send(2, w);
            capture(2, 20);
        join
        exp_sent[2] = exp_sent[2] + 16'd1;
        n = got.size();
        n_tests++;
        if (n != 8) begin n_fail++; $display("FAIL lsb_count: got %0d valid bits, required 8", n); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 1'bx;
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL lsb_bit%0d: got %b, required %b", idx, a, e); end
            idx++;
        end
        n_tests++;
        if (ws_c !== exp_sent[2]) begin n_fail++; $display("FAIL lsb_words_sent: got %0d, required %0d", ws_c, exp_sent[2]); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut_a.words_sent = 16'hFFFF;
        @(negedge clk);
        release dut_a.words_sent;
        exp_sent[0] = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            fork
                send(0, 8'h3C);
                capture(0, 14);
            join
            exp_sent[0] = exp_sent[0] + 16'd1;
            n_tests++;
            if (ws_a !== exp_sent[0]) begin
                n_fail++;
                $display("FAIL wrap_words_sent%0d: got %0h, required %0h", k, ws_a, exp_sent[0]);
            end
        end
    endtask

    task automatic test_reset_midword();
        send(0, 8'hFF);
        send(0, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (dout_a !== 1'b1 || dv_a !== 1'b1 || ifa.in_ready !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midword_pre: dout/valid/ready/busy=%b%b%b%b, required 1101", dout_a, dv_a, ifa.in_ready, busy_a);
        end
        rst = 1'b1;
        #1;
        exp_sent[0] = 16'd0;
        exp_sent[1] = 16'd0;
        exp_sent[2] = 16'd0;
        n_tests++;
        if (dout_a !== 1'b0 || dv_a !== 1'b0 || ifa.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midword_reset: dout/valid/ready/busy=%b%b%b%b, required 0010", dout_a, dv_a, ifa.in_ready, busy_a);
        end
        n_tests++;
        if (ws_a !== exp_sent[0]) begin n_fail++; $display("FAIL midword_words_sent: got %0d, required %0d", ws_a, exp_sent[0]); end
        @(negedge clk);
        rst = 1'b0;
        capture(0, 30);
        n_tests++;
        if (got.size() != 0) begin n_fail++; $display("FAIL midword_after: got %0d bits after release, required 0", got.size()); end
        n_tests++;
        if (ws_a !== exp_sent[0] || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midword_idle: ws=%0d busy=%b, required %0d 0", ws_a, busy_a, exp_sent[0]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_sent[0] = 16'd0;
        exp_sent[1] = 16'd0;
        exp_sent[2] = 16'd0;
        rst = 1'b1;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);

        test_reset();
        test_single();
        test_back_to_back();
        test_div();
        test_lsb_first();
        test_wrap();
        test_reset_midword();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
